vga_sync_gen: RTL
=================

Name: vga_sync_gen

Overview:
- VGA timing generator. Sits directly downstream of the pixel-rate clock divider.
- Consumes the divider's pixel-rate output as a single-cycle enable (pix_tick) in the clk_in domain, never as a clock.
- Produces hsync, vsync, video_on and pixel coordinates for the pixel/colour stage.
- Default timing is 640x480@60 (800x525 total).

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- Derived localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk_in  input  1  system clock (only clock)
- reset  input  1  synchronous, active-high reset
- pix_tick  input  1  pixel enable, one clk_in cycle wide, from the clock divider
- hsync  output  1  horizontal sync, registered
- vsync  output  1  vertical sync, registered
- video_on  output  1  high while (pixel_x, pixel_y) is in the visible area, registered
- pixel_x  output  HW  current column, 0..H_TOTAL-1
- pixel_y  output  VW  current line, 0..V_TOTAL-1
- frame_start  output  1  one clk_in-cycle pulse when the coordinates become (0,0)
- rgb  output  3  test-pattern colour; exists only with VGA_TEST_PATTERN_EN

Behaviour:
- Clocking and reset: one clock, clk_in; reset is synchronous and active-high. All state changes on posedge clk_in.
- Reset values:
  - State ST_IDLE; counters 0; pixel_x = 0, pixel_y = 0.
  - hsync and vsync at the inactive level (~SYNC_POL).
  - video_on = 0, frame_start = 0, rgb = 0.
- FSM, two states:
  - ST_IDLE: on the first pix_tick, hold counters at (0,0), load the output decode for (0,0), pulse frame_start, go to ST_RUN. With no pix_tick, hold everything.
  - ST_RUN: advance only on cycles with pix_tick=1. With pix_tick=0, every output and counter holds, and frame_start = 0.
- Counting:
  - pixel_x increments by 1 and wraps H_TOTAL-1 -> 0.
  - On that wrap, pixel_y increments and wraps V_TOTAL-1 -> 0.
  - The simultaneous wrap to (0,0) pulses frame_start for exactly 1 clk_in cycle, even if pix_tick is asserted on consecutive cycles.
- Decode:
  - hsync, vsync and video_on are computed from the next counter values and registered, so they are cycle-aligned with pixel_x/pixel_y with zero skew.
  - hsync is active for x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]; defaults 656..751.
  - vsync is active for y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]; defaults 490..491.
  - video_on = (x < H_VISIBLE) && (y < V_VISIBLE).
- pix_tick may be asserted every cycle (divide ratio 1) or sparsely; the output sequence per tick is identical either way.
- Reset mid-frame: on the next edge, all registers return to reset values and the FSM returns to ST_IDLE. No partial frame_start is generated.
- Counters never exceed TOTAL-1. Widths are exactly HW/VW; no overflow is possible.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined: adds the rgb port, registered and aligned with video_on.
  - While video_on = 1: rgb = bar index = pixel_x / (H_VISIBLE/8), giving 8 vertical colour bars 0..7.
  - While video_on = 0: rgb = 0.
  - Reset value 0.
- Undefined: no rgb port and no pattern logic. All other behaviour is unchanged.

Test Plan:
1. Reset 3 cycles, then pix_tick every cycle -> first tick gives frame_start=1 for 1 cycle, (0,0), video_on=1, hsync=1, vsync=1.
2. Continue ticking -> hsync=0 exactly at x=656..751 (96 ticks), back to 1 at x=752; video_on=0 for x=640..799.
3. Line wrap -> x goes 799->0 and y increments by 1 on the same edge; at (799,524) the next tick gives (0,0) plus frame_start.
4. Full frame -> vsync=0 for y=490..491 (1600 ticks); successive frame_start pulses exactly 420000 ticks apart.
5. pix_tick every 4th cycle, plus pix_tick held 0 for 10 cycles at x=100 -> outputs frozen during the gap; per-tick sequence identical to scenario 2.
6. Reset asserted at (300,200) -> next edge: x=y=0, hsync=vsync=1, video_on=0, frame_start=0; next pix_tick restarts the frame as in scenario 1.
   - With VGA_TEST_PATTERN_EN defined: rgb=0 at x=0..79, rgb=1 at x=80, rgb=7 at x=560..639, rgb=0 at x=640.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator driven by a single-cycle pixel enable in the clk_in domain.
// Define VGA_TEST_PATTERN_EN to add the registered 8-bar rgb test pattern output.
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 0,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic          clk_in,
    input  logic          reset,
    input  logic          pix_tick,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [2:0]    rgb
`endif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic          SYNC_ACT = (SYNC_POL != 0);

    logic [0:0]    state_q, state_d;
    logic [HW-1:0] x_q, x_d;
    logic [VW-1:0] y_q, y_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          video_q, video_d;
    logic          fs_q, fs_d;
    logic          advance;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0] rgb_q, rgb_d;

    function automatic logic [2:0] bar_of(input logic [HW-1:0] x);
        logic [2:0] bar;
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (x >= HW'(k * BAR_W)) bar = 3'(k);
        end
        return bar;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        fs_d    = 1'b0;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pix_tick) begin
                    x_d     = '0;
                    y_d     = '0;
                    fs_d    = 1'b1;
                    advance = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pix_tick) begin
                    advance = 1'b1;
                    if (x_q == H_LAST) begin
                        x_d = '0;
                        if (y_q == V_LAST) begin
                            y_d  = '0;
                            fs_d = 1'b1;
                        end else begin
                            y_d = y_q + 1'b1;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decode from the next coordinates so syncs land on the same edge as the counters.
    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        video_d = video_q;
`ifdef VGA_TEST_PATTERN_EN
        rgb_d   = rgb_q;
`endif
        if (advance) begin
            hsync_d = (x_d >= H_SYNC_S && x_d <= H_SYNC_E) ? SYNC_ACT : ~SYNC_ACT;
            vsync_d = (y_d >= V_SYNC_S && y_d <= V_SYNC_E) ? SYNC_ACT : ~SYNC_ACT;
            video_d = (x_d < H_VIS) && (y_d < V_VIS);
`ifdef VGA_TEST_PATTERN_EN
            rgb_d   = video_d ? bar_of(x_d) : 3'd0;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            hsync_q <= ~SYNC_ACT;
            vsync_q <= ~SYNC_ACT;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
`ifdef VGA_TEST_PATTERN_EN
            rgb_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            fs_q    <= fs_d;
`ifdef VGA_TEST_PATTERN_EN
            rgb_q   <= rgb_d;
`endif
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign frame_start = fs_q;
`ifdef VGA_TEST_PATTERN_EN
    assign rgb         = rgb_q;
`endif

endmodule
